// File: rtl/vslc_timer_pkg.sv
// Shared encodings for the timer bank: config selects, channel modes,
// control-word bit positions and the per-channel state machine states.
package vslc_timer_pkg;

  localparam logic [1:0] SEL_PERIOD_A = 2'd0;
  localparam logic [1:0] SEL_PERIOD_B = 2'd1;
  localparam logic [1:0] SEL_CTRL     = 2'd2;
  localparam logic [1:0] SEL_NONE     = 2'd3;

  typedef enum logic {
    MODE_CYCLE   = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2
  } chan_state_t;

  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_D_LSB    = 1;

  localparam int RST_PERIOD_A = 1;
  localparam int RST_PERIOD_B = 2;

  // The invert flag sits just above the prescaler exponent field.
  function automatic int ctrl_inv_bit(input int divw);
    return divw + 1;
  endfunction

endpackage

// File: rtl/vslc_timer_chan.sv
// One timer channel: prescaled two-phase (A low, B high) waveform with
// shadowed periods, cycle/oneshot modes and an output invert.
module vslc_timer_chan
  import vslc_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIVW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             en_set,
  input  logic             en_clr,
  output logic             tmr_out,
  output logic             busy,
  output logic             done
);

  localparam int PW      = 2 ** DIVW;
  localparam int INV_BIT = ctrl_inv_bit(DIVW);

  chan_state_t      state, state_nxt;
  logic [WIDTH-1:0] period_a, period_b, shadow_a, shadow_b;
  logic [WIDTH-1:0] shadow_a_nxt, shadow_b_nxt;
  logic [WIDTH-1:0] cnt;
  logic [PW-1:0]    pre, pre_mask;
  logic [DIVW-1:0]  d;
  mode_t            mode;
  logic             invert;
  logic             tick, end_a, end_b, boundary;
  logic             wr_a, wr_b, wr_ctrl;

  assign pre_mask     = (PW'(1) << d) - PW'(1);
  assign tick         = (state != ST_IDLE) && (pre == pre_mask);
  assign end_a        = (state == ST_A) && tick && (cnt == period_a);
  assign end_b        = (state == ST_B) && tick && (cnt == period_b);
  assign boundary     = end_a || end_b;
  assign wr_a         = cfg_we && (cfg_sel == SEL_PERIOD_A);
  assign wr_b         = cfg_we && (cfg_sel == SEL_PERIOD_B);
  assign wr_ctrl      = cfg_we && (cfg_sel == SEL_CTRL);
  assign shadow_a_nxt = wr_a ? cfg_data : shadow_a;
  assign shadow_b_nxt = wr_b ? cfg_data : shadow_b;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // en_clr has priority over both starting and phase completion.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en_set && !en_clr) state_nxt = ST_A;
      ST_A: begin
        if (en_clr)     state_nxt = ST_IDLE;
        else if (end_a) state_nxt = ST_B;
      end
      ST_B: begin
        if (en_clr)     state_nxt = ST_IDLE;
        else if (end_b) state_nxt = (mode == MODE_ONESHOT) ? ST_IDLE : ST_A;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    tmr_out = (state == ST_B) ^ invert;
  end

  // An idle channel mirrors its shadows continuously, so a period write
  // lands immediately; a running one picks them up at each phase boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_a <= WIDTH'(RST_PERIOD_A);
      period_b <= WIDTH'(RST_PERIOD_B);
      shadow_a <= WIDTH'(RST_PERIOD_A);
      shadow_b <= WIDTH'(RST_PERIOD_B);
      mode     <= MODE_CYCLE;
      d        <= '0;
      invert   <= 1'b0;
      cnt      <= '0;
      pre      <= '0;
      done     <= 1'b0;
    end else begin
      shadow_a <= shadow_a_nxt;
      shadow_b <= shadow_b_nxt;
      if ((state == ST_IDLE) || boundary) begin
        period_a <= shadow_a_nxt;
        period_b <= shadow_b_nxt;
      end
      if (wr_ctrl && (state == ST_IDLE)) begin
        mode   <= mode_t'(cfg_data[CTRL_MODE_BIT]);
        d      <= cfg_data[CTRL_D_LSB +: DIVW];
        invert <= cfg_data[INV_BIT];
      end
      if ((state == ST_IDLE) || (state_nxt != state)) begin
        cnt <= '0;
        pre <= '0;
      end else if (tick) begin
        cnt <= cnt + WIDTH'(1);
        pre <= '0;
      end else begin
        pre <= pre + PW'(1);
      end
      done <= end_b && !en_clr;
    end
  end

endmodule

// File: rtl/vslc_timer_bank.sv
// Bank of NCH independent timer channels sharing one configuration port.
module vslc_timer_bank
  import vslc_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int DIVW  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                            cfg_sel,
  input  logic [WIDTH-1:0]                      cfg_data,
  input  logic [NCH-1:0]                        en_set,
  input  logic [NCH-1:0]                        en_clr,
  output logic [NCH-1:0]                        tmr_out,
  output logic [NCH-1:0]                        busy,
  output logic [NCH-1:0]                        done
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  // Channel indices at or above NCH match no instance, so those writes drop.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    vslc_timer_chan #(
      .WIDTH(WIDTH),
      .DIVW (DIVW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .cfg_we  (cfg_we && (cfg_ch == CHW'(i))),
      .cfg_sel (cfg_sel),
      .cfg_data(cfg_data),
      .en_set  (en_set[i]),
      .en_clr  (en_clr[i]),
      .tmr_out (tmr_out[i]),
      .busy    (busy[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_vslc_timer_bank.sv
// Self-checking bench for vslc_timer_bank: directed scenarios with literal
// expectations, then randomized traffic compared against an elapsed-time model.
module tb_vslc_timer_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int DIVW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_sel = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic [NCH-1:0]   en_set = '0;
  logic [NCH-1:0]   en_clr = '0;
  logic [NCH-1:0]   tmr_out, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_valid = 1'b0;

  always #5 clk = ~clk;

  vslc_timer_bank #(
    .NCH  (NCH),
    .WIDTH(WIDTH),
    .DIVW (DIVW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_sel (cfg_sel),
    .cfg_data(cfg_data),
    .en_set  (en_set),
    .en_clr  (en_clr),
    .tmr_out (tmr_out),
    .busy    (busy),
    .done    (done)
  );

  // Model: each running channel counts raw clocks spent in its phase; the
  // phase ends once (period+1) * 2^d clocks have elapsed.
  bit     m_busy[NCH], m_phase[NCH], m_done[NCH], m_mode[NCH], m_inv[NCH];
  int     m_d[NCH], m_pa[NCH], m_pb[NCH], m_sa[NCH], m_sb[NCH];
  longint m_el[NCH];

  bit     we_i, hit, was_busy;
  longint lim;

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_phase[i] = 0; m_done[i] = 0; m_mode[i] = 0; m_inv[i] = 0;
        m_d[i] = 0; m_pa[i] = 1; m_sa[i] = 1; m_pb[i] = 2; m_sb[i] = 2; m_el[i] = 0;
      end else begin
        m_done[i] = 0;
        was_busy  = m_busy[i];
        we_i      = cfg_we && (int'(cfg_ch) == i);
        hit       = 0;
        if (was_busy) begin
          lim = (longint'(m_phase[i] ? m_pb[i] : m_pa[i]) + 1) << m_d[i];
          hit = (m_el[i] + 1 == lim);
        end
        if (we_i && cfg_sel == 2'd0) m_sa[i] = int'(cfg_data);
        if (we_i && cfg_sel == 2'd1) m_sb[i] = int'(cfg_data);
        if (!was_busy || hit) begin
          m_pa[i] = m_sa[i];
          m_pb[i] = m_sb[i];
        end
        if (!was_busy && we_i && cfg_sel == 2'd2) begin
          m_mode[i] = cfg_data[0];
          m_d[i]    = int'(cfg_data[4:1]);
          m_inv[i]  = cfg_data[5];
        end
        if (was_busy) begin
          if (en_clr[i]) begin
            m_busy[i] = 0; m_phase[i] = 0; m_el[i] = 0;
          end else if (hit) begin
            m_el[i] = 0;
            if (m_phase[i]) begin
              m_done[i]  = 1;
              m_phase[i] = 0;
              if (m_mode[i]) m_busy[i] = 0;
            end else begin
              m_phase[i] = 1;
            end
          end else begin
            m_el[i] = m_el[i] + 1;
          end
        end else if (en_set[i] && !en_clr[i]) begin
          m_busy[i] = 1; m_phase[i] = 0; m_el[i] = 0;
        end
      end
    end
    model_valid = 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [NCH-1:0] eb, et, ed;

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < NCH; i++) begin
        eb[i] = m_busy[i];
        et[i] = (m_busy[i] && m_phase[i]) ^ m_inv[i];
        ed[i] = m_done[i];
      end
      check_output("model_busy", 32'(busy), 32'(eb));
      check_output("model_tmr_out", 32'(tmr_out), 32'(et));
      check_output("model_done", 32'(done), 32'(ed));
    end
  end

  // Holds the given inputs across one rising edge, returning on the next falling edge.
  task automatic apply_stimulus(input logic we, input logic [1:0] ch, input logic [1:0] sel,
                                input logic [WIDTH-1:0] data,
                                input logic [NCH-1:0] set, input logic [NCH-1:0] clr);
    cfg_we = we; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    en_set = set; en_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 2'd0, 2'd0, '0, '0, '0);
  endtask

  initial begin
    logic [9:0] exp_t, exp_d;
    int lo, hi, dn;

    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_tmr_out", 32'(tmr_out), 32'h0);
    check_output("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Defaults: low 2, high 3, done every 5 clocks.
    exp_t = 10'b1110011100;
    exp_d = 10'b0000100000;
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, 4'b0001, '0);
    for (int k = 0; k < 10; k++) begin
      check_output($sformatf("ch0_tmr_k%0d", k + 1), 32'(tmr_out[0]), 32'(exp_t[k]));
      check_output($sformatf("ch0_done_k%0d", k + 1), 32'(done[0]), 32'(exp_d[k]));
      idle(1);
    end
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, '0, 4'b0001);

    // Oneshot, d=2, A=3, B=1.
    apply_stimulus(1'b1, 2'd1, 2'd2, 16'h0005, '0, '0);
    apply_stimulus(1'b1, 2'd1, 2'd0, 16'd3, '0, '0);
    apply_stimulus(1'b1, 2'd1, 2'd1, 16'd1, '0, '0);
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, 4'b0010, '0);
    lo = 0; hi = 0; dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy[1] && !tmr_out[1]) lo++;
      if (tmr_out[1]) hi++;
      if (done[1]) dn++;
      idle(1);
    end
    check_output("ch1_low_clks", 32'(lo), 32'd16);
    check_output("ch1_high_clks", 32'(hi), 32'd8);
    check_output("ch1_done_count", 32'(dn), 32'd1);
    check_output("ch1_busy_end", 32'(busy[1]), 32'd0);

    // Inverted channel stopped mid phase B.
    apply_stimulus(1'b1, 2'd2, 2'd2, 16'h0020, '0, '0);
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, 4'b0100, '0);
    check_output("ch2_inv_phase_a", 32'(tmr_out[2]), 32'd1);
    idle(2);
    check_output("ch2_inv_phase_b", 32'(tmr_out[2]), 32'd0);
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, '0, 4'b0100);
    check_output("ch2_clr_tmr", 32'(tmr_out[2]), 32'd1);
    check_output("ch2_clr_busy", 32'(busy[2]), 32'd0);
    check_output("ch2_clr_done", 32'(done[2]), 32'd0);

    // Set+clr together; then a ctrl write while running must not stick.
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, 4'b1000, 4'b1000);
    check_output("ch3_set_clr_idle", 32'(busy[3]), 32'd0);
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, 4'b1000, '0);
    apply_stimulus(1'b1, 2'd3, 2'd2, 16'h0007, '0, '0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      if (done[3]) dn++;
      idle(1);
    end
    check_output("ch3_ctrl_ignored_done", 32'(dn), 32'd2);
    check_output("ch3_still_busy", 32'(busy[3]), 32'd1);
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, '0, 4'b1000);

    // Reset during ch0 phase B.
    apply_stimulus(1'b0, 2'd0, 2'd0, '0, 4'b0001, '0);
    idle(2);
    check_output("ch0_in_b", 32'(tmr_out[0]), 32'd1);
    rst_n = 1'b0;
    idle(1);
    check_output("midrst_busy", 32'(busy), 32'h0);
    check_output("midrst_tmr_out", 32'(tmr_out), 32'h0);
    check_output("midrst_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]       sel;
      logic [WIDTH-1:0] data;
      logic [NCH-1:0]   s, c;
      sel = 2'($urandom_range(0, 3));
      if (sel == 2'd2)
        data = {10'($urandom), 1'($urandom), 4'($urandom_range(0, 2)), 1'($urandom)};
      else if ($urandom_range(0, 49) == 0)
        data = 16'hFFFF;
      else
        data = 16'($urandom_range(0, 6));
      for (int i = 0; i < NCH; i++) begin
        s[i] = ($urandom_range(0, 3) == 0);
        c[i] = ($urandom_range(0, 31) == 0);
      end
      rst_n = ($urandom_range(0, 499) != 0);
      apply_stimulus(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), sel, data, s, c);
    end
    rst_n = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vslc_timer_bank.md
VSLC_TIMER_BANK -- requirements
Module: vslc_timer_bank

Interface
REQ-001 SHALL take parameter NCH, default 4: number of independent timer channels (1..8).
REQ-002 SHALL take parameter WIDTH, default 16: period and counter width in bits (8..24).
REQ-003 SHALL take parameter DIVW, default 4: prescaler exponent width; the divisor is 2^d clk cycles, d in 0..2^DIVW-1.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port cfg_we, input, 1: configuration write strobe, one write per asserted cycle.
REQ-007 SHALL have port cfg_ch, input, $clog2(NCH) (min 1): target channel; writes to ch >= NCH are ignored.
REQ-008 SHALL have port cfg_sel, input, 2: 0=period_a, 1=period_b, 2=ctrl, 3=ignored.
REQ-009 SHALL have port cfg_data, input, WIDTH: write data; ctrl uses bit0=mode (0 cycle, 1 oneshot), bits[DIVW:1]=d, bit[DIVW+1]=invert.
REQ-010 SHALL have ports en_set and en_clr, input, NCH: per-channel start and stop requests.
REQ-011 SHALL have port tmr_out, output, NCH: per-channel timer waveform.
REQ-012 SHALL have port busy, output, NCH: channel running.
REQ-013 SHALL have port done, output, NCH: one-clk pulse at each completed A+B period.

Function
REQ-014 Each channel SHALL hold active period_a, period_b, mode, d, invert, plus shadow_a and shadow_b.
REQ-015 A cfg write to period_a/period_b SHALL load the shadow; an idle channel copies shadow to active in the same cycle, a busy channel only at its next A-to-B or B-to-A boundary.
REQ-016 ctrl writes SHALL take effect immediately when idle and SHALL be ignored while busy.
REQ-017 Prescaler: a busy channel SHALL issue one tick every 2^d clk cycles, the first tick 2^d cycles after start.
REQ-018 Phase A SHALL last period_a+1 ticks with raw output 0; phase B SHALL last period_b+1 ticks with raw output 1.
REQ-019 tmr_out SHALL equal raw output XOR invert; idle raw output SHALL be 0.
REQ-020 At the end of phase B, done SHALL pulse for exactly one clk; cycle mode returns to phase A, oneshot mode drops busy and returns raw output to 0 in that same cycle.
REQ-021 en_set on an idle channel SHALL start it in phase A with counters zero and busy=1 from the next cycle; en_set on a busy channel SHALL be ignored.
REQ-022 en_clr SHALL stop the channel on the next edge: busy=0, counters zero, raw output 0, no done pulse.
REQ-023 en_clr and en_set on the same channel in the same cycle: en_clr SHALL win.
REQ-024 Counters SHALL compare with equality only, never wrap past period; an all-ones period SHALL be legal.
REQ-025 A cfg write in the same cycle as a phase boundary SHALL be applied at that boundary (write-through).
REQ-026 Channels SHALL be fully independent; simultaneous writes to multiple channels are impossible by interface.

Reset
REQ-027 With rst_n low at a clk edge: tmr_out=0, busy=0, done=0, period_a=shadow_a=1, period_b=shadow_b=2, mode=cycle, d=0, invert=0, all counters zero.
REQ-028 Reset mid-operation SHALL abort the period without a done pulse.

Structure
REQ-029 Package vslc_timer_pkg SHALL hold the cfg_sel encodings, mode encodings and ctrl bit positions.
REQ-030 Per-channel logic SHALL be sub-module vslc_timer_chan (params WIDTH, DIVW), instantiated NCH times by generate.

Verification
REQ-031 Reset defaults, ch0 en_set, d=0 -> tmr_out[0] low 2 clk, high 3 clk, repeating; done[0] pulses every 5 clk.
REQ-032 ch1 ctrl=oneshot, d=2, period_a=3, period_b=1, en_set -> low 16 clk, high 8 clk, one done pulse, busy drops, no further activity.
REQ-033 ch0 running, write period_b=7 mid-phase-A -> current phase B still uses old value only if already in B; next B lasts 8 ticks.
REQ-034 ch2 invert=1, en_clr mid-phase-B -> tmr_out[2]=1 (idle inverted) next cycle, busy=0, no done.
REQ-035 Same-cycle en_set and en_clr on ch3 -> ch3 stays idle; ctrl write while busy -> mode and d unchanged.
REQ-036 rst_n low during ch0 phase B -> all outputs at reset values next cycle, no done pulse.
